// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one single-ported synchronous memory between an instruction-fetch
//   port (read only) and a data port (read/write). At most one access is
//   issued per cycle. Read data returns one cycle after the access and is
//   routed back to whichever port issued it. Back-to-back accesses are
//   allowed, so one access per cycle is sustained.
//
// Configuration:
//   MEM_ARB_ROUND_ROBIN_EN  defined   -> contested cycles alternate between the
//                                        ports. A one-bit pointer records which
//                                        port wins the next contested cycle.
//                           undefined -> fixed priority. The data port always
//                                        wins and there is no pointer.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ifReq/ifAddr               fetch request and address
//   ifGnt                      fetch accepted this cycle (combinational)
//   ifRvalid/ifRdata           fetch read response
//   dReq/dWe/dMask/dAddr/dWdata data request (read or masked write)
//   dGnt                       data accepted this cycle (combinational)
//   dRvalid/dRdata             data read response
//   memEn/memWe/memMask/memAddr/memWdata  memory command
//   memRdata                   memory read data, one cycle after a read
// -----------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  // instruction fetch port
  input  logic                ifReq,
  input  logic [ADDR_W-1:0]   ifAddr,
  output logic                ifGnt,
  output logic                ifRvalid,
  output logic [DATA_W-1:0]   ifRdata,
  // data port
  input  logic                dReq,
  input  logic                dWe,
  input  logic [DATA_W/8-1:0] dMask,
  input  logic [ADDR_W-1:0]   dAddr,
  input  logic [DATA_W-1:0]   dWdata,
  output logic                dGnt,
  output logic                dRvalid,
  output logic [DATA_W-1:0]   dRdata,
  // memory side
  output logic                memEn,
  output logic                memWe,
  output logic [DATA_W/8-1:0] memMask,
  output logic [ADDR_W-1:0]   memAddr,
  output logic [DATA_W-1:0]   memWdata,
  input  logic [DATA_W-1:0]   memRdata
);

  localparam int MASK_W = DATA_W / 8;

  // Response tracking: which port, if any, owns the read data arriving now.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND_IF = 2'd1,
    PEND_D  = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;

  logic if_gnt_s;
  logic d_gnt_s;
  logic contested_s;

  assign contested_s = ifReq & dReq;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // High when the data port wins the next contested cycle.
  logic prefer_d_q;
  logic prefer_d_d;
`endif

  // Grant decision. Reset blocks all grants so no memory access starts
  // and no response becomes pending while reset is high.
  always_comb begin
    if_gnt_s = 1'b0;
    d_gnt_s  = 1'b0;
    if (reset) begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
    end else if (contested_s) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (prefer_d_q) begin
        d_gnt_s = 1'b1;
      end else begin
        if_gnt_s = 1'b1;
      end
`else
      d_gnt_s = 1'b1;
`endif
    end else if (dReq) begin
      d_gnt_s = 1'b1;
    end else if (ifReq) begin
      if_gnt_s = 1'b1;
    end else begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
    end
  end

  assign ifGnt = if_gnt_s;
  assign dGnt  = d_gnt_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // The pointer moves only when both ports asked. It then points at the
  // port that lost, so the loser wins the next contested cycle.
  always_comb begin
    prefer_d_d = prefer_d_q;
    if (contested_s && !reset) begin
      prefer_d_d = if_gnt_s;
    end else begin
      prefer_d_d = prefer_d_q;
    end
  end

  // Round-robin pointer register. After reset the data port is favoured.
  always_ff @(posedge clk) begin
    if (reset) begin
      prefer_d_q <= 1'b1;
    end else begin
      prefer_d_q <= prefer_d_d;
    end
  end
`endif

  // Memory command mux. A fetch is always a full-width read. When no
  // request is granted, the command lines are driven to zero.
  always_comb begin
    memEn    = 1'b0;
    memWe    = 1'b0;
    memMask  = {MASK_W{1'b0}};
    memAddr  = {ADDR_W{1'b0}};
    memWdata = {DATA_W{1'b0}};
    if (d_gnt_s) begin
      memEn    = 1'b1;
      memWe    = dWe;
      memMask  = dMask;
      memAddr  = dAddr;
      memWdata = dWdata;
    end else if (if_gnt_s) begin
      memEn    = 1'b1;
      memWe    = 1'b0;
      memMask  = {MASK_W{1'b1}};
      memAddr  = ifAddr;
      memWdata = {DATA_W{1'b0}};
    end else begin
      memEn    = 1'b0;
      memWe    = 1'b0;
    end
  end

  // Next response owner. The state is decided only by this cycle's grant,
  // so a new access can overlap the response of the previous one.
  always_comb begin
    state_d = IDLE;
    if (if_gnt_s) begin
      state_d = PEND_IF;
    end else if (d_gnt_s && !dWe) begin
      state_d = PEND_D;
    end else begin
      state_d = IDLE;
    end
  end

  // Response state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read valids. These are gated by reset because state_q can still hold
  // a pending response in the first reset cycle. That response is dropped.
  always_comb begin
    ifRvalid = 1'b0;
    dRvalid  = 1'b0;
    if (reset) begin
      ifRvalid = 1'b0;
      dRvalid  = 1'b0;
    end else begin
      case (state_q)
        PEND_IF: ifRvalid = 1'b1;
        PEND_D:  dRvalid  = 1'b1;
        IDLE:    ifRvalid = 1'b0;
        default: begin
          ifRvalid = 1'b0;
          dRvalid  = 1'b0;
        end
      endcase
    end
  end

  // Read data is a plain pass-through and is only meaningful with its valid.
  assign ifRdata = memRdata;
  assign dRdata  = memRdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps

module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        ifGnt;
  logic        ifRvalid;
  logic [31:0] ifRdata;
  logic        dReq;
  logic        dWe;
  logic [3:0]  dMask;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic        dGnt;
  logic        dRvalid;
  logic [31:0] dRdata;
  logic        memEn;
  logic        memWe;
  logic [3:0]  memMask;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt),
    .ifRvalid(ifRvalid), .ifRdata(ifRdata),
    .dReq(dReq), .dWe(dWe), .dMask(dMask), .dAddr(dAddr), .dWdata(dWdata),
    .dGnt(dGnt), .dRvalid(dRvalid), .dRdata(dRdata),
    .memEn(memEn), .memWe(memWe), .memMask(memMask), .memAddr(memAddr),
    .memWdata(memWdata), .memRdata(memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model. owner: 0 = no read outstanding, 1 = fetch, 2 = data.
  int   owner;
  logic exp_if_g;
  logic exp_d_g;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic next_is_d;   // which port wins the next contested cycle
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs after the falling edge, then compare every
  // combinational output with the model.
  task automatic drive(input logic rst, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic we, input logic [3:0] m,
                       input logic [31:0] da, input logic [31:0] wd,
                       input logic [31:0] rd);
    @(negedge clk);
    reset = rst; ifReq = ir; ifAddr = ia; dReq = dr; dWe = we;
    dMask = m; dAddr = da; dWdata = wd; memRdata = rd;
    #1;
    if (rst) begin
      exp_if_g = 1'b0; exp_d_g = 1'b0;
    end else if (ir && dr) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_d_g = next_is_d;
`else
      exp_d_g = 1'b1;
`endif
      exp_if_g = ~exp_d_g;
    end else begin
      exp_d_g = dr; exp_if_g = ir;
    end
    chk("ifGnt", ifGnt, exp_if_g);
    chk("dGnt", dGnt, exp_d_g);
    chk("memEn", memEn, exp_if_g | exp_d_g);
    chk("memWe", memWe, exp_d_g & we);
    if (exp_d_g) begin
      chk("memAddr_d", memAddr, da);
      chk("memMask_d", memMask, m);
      if (we) chk("memWdata", memWdata, wd);
    end
    if (exp_if_g) begin
      chk("memAddr_if", memAddr, ia);
      chk("memMask_if", memMask, 4'hF);
    end
    chk("ifRvalid", ifRvalid, !rst && owner == 1);
    chk("dRvalid", dRvalid, !rst && owner == 2);
    if (!rst && owner == 1) chk("ifRdata", ifRdata, rd);
    if (!rst && owner == 2) chk("dRdata", dRdata, rd);
  endtask

  // Advance the model across the rising edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      owner = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      next_is_d = 1'b1;
`endif
    end else begin
      if (exp_if_g)                owner = 1;
      else if (exp_d_g && !dWe)    owner = 2;
      else                         owner = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (ifReq && dReq) next_is_d = exp_if_g;
`endif
    end
  endtask

  task automatic idle(input logic rst, input logic [31:0] rd);
    drive(rst, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rd);
    tick();
  endtask

  logic [3:0] gpat;
  logic [3:0] gexp;

  initial begin
    owner = 0; exp_if_g = 1'b0; exp_d_g = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    next_is_d = 1'b1;
`endif
    reset = 1'b1; ifReq = 1'b0; ifAddr = 32'h0; dReq = 1'b0; dWe = 1'b0;
    dMask = 4'h0; dAddr = 32'h0; dWdata = 32'h0; memRdata = 32'h0;

    // Reset state, including requests held high during reset.
    idle(1'b1, 32'h0);
    drive(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0, 32'h0);
    chk("rst_gnt", {ifGnt, dGnt, memEn, memWe}, 4'b0000);
    tick();
    idle(1'b0, 32'h0);

    // Single fetch, one-cycle read latency.
    drive(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    chk("fetch_gnt", ifGnt, 1'b1);
    chk("fetch_addr", memAddr, 32'h10);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF);
    chk("fetch_rvalid", ifRvalid, 1'b1);
    chk("fetch_rdata", ifRdata, 32'hDEADBEEF);
    tick();

    // Masked write, with no response afterwards.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h104, 32'h1234, 32'h0);
    chk("wr_gnt", {dGnt, memWe, memMask}, {1'b1, 1'b1, 4'h3});
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h5555);
    chk("wr_norvalid", dRvalid, 1'b0);
    tick();

    // Both ports request for four cycles.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'h200 + i * 4, 1'b1, 1'b1, 4'hF, 32'h300, 32'h77, 32'h0);
      gpat[i] = dGnt;
      tick();
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    gexp = 4'b0101;
`else
    gexp = 4'b1111;
`endif
    chk("contest_pattern", gpat, gexp);
    idle(1'b0, 32'h0);

    // Three back-to-back data reads.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, i * 4, 32'h0, 32'hA0 + i);
      else       drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hA0 + i);
      if (i > 0) chk("b2b_rdata", {dRvalid, dRdata}, {1'b1, 32'hA0 + i});
      tick();
    end

    // A fetch response outstanding when reset arrives is discarded.
    drive(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h99);
    chk("rst_drop_during", ifRvalid, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h98);
    chk("rst_drop_after", ifRvalid, 1'b0);
    tick();

    // Random traffic checked against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
            $urandom, $urandom, $urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, width of all address buses.
REQ-002 Parameter: DATA_W, default 32, width of all data buses; the mask width is DATA_W/8.
REQ-003 Port: clk  in  1  clock; all state updates on the rising edge.
REQ-004 Port: reset  in  1  reset, synchronous, active-high.
REQ-005 Port: ifReq  in  1  instruction-fetch read request.
REQ-006 Port: ifAddr  in  ADDR_W  fetch address.
REQ-007 Port: ifGnt  out  1  fetch request accepted this cycle.
REQ-008 Port: ifRvalid  out  1  fetch read data valid.
REQ-009 Port: ifRdata  out  DATA_W  fetch read data.
REQ-010 Port: dReq  in  1  data-port request.
REQ-011 Port: dWe  in  1  data write enable; low means read.
REQ-012 Port: dMask  in  DATA_W/8  byte write mask.
REQ-013 Port: dAddr  in  ADDR_W  data address.
REQ-014 Port: dWdata  in  DATA_W  data write value.
REQ-015 Port: dGnt  out  1  data request accepted this cycle.
REQ-016 Port: dRvalid  out  1  data read data valid.
REQ-017 Port: dRdata  out  DATA_W  data read data.
REQ-018 Port: memEn  out  1  memory access strobe.
REQ-019 Port: memWe  out  1  memory write enable.
REQ-020 Port: memMask  out  DATA_W/8  memory byte mask.
REQ-021 Port: memAddr  out  ADDR_W  memory address.
REQ-022 Port: memWdata  out  DATA_W  memory write data.
REQ-023 Port: memRdata  in  DATA_W  memory read data, valid one cycle after memEn with memWe low.

Function
REQ-024 The block SHALL grant at most one requester per cycle; ifGnt and dGnt are combinational from the requests and the arbitration state, and are never high together.
REQ-025 On a grant, memEn SHALL be high in the same cycle; memAddr, memWe, memMask and memWdata SHALL be driven from the granted port. A fetch grant drives memWe=0 and memMask=all ones.
REQ-026 With no grant, memEn SHALL be 0 and memWe SHALL be 0.
REQ-027 Response tracking SHALL use the states IDLE, PEND_IF and PEND_D.
 - A granted fetch moves the FSM to PEND_IF.
 - A granted data read moves it to PEND_D.
 - A granted write, or no grant, moves it to IDLE.
REQ-028 In PEND_IF, ifRvalid SHALL be 1 and ifRdata=memRdata. In PEND_D, dRvalid SHALL be 1 and dRdata=memRdata. In every other case the valids are 0.
REQ-029 The read latency SHALL be exactly 1 cycle from grant to rvalid. A new grant SHALL be allowed in the same cycle as a pending response, giving one access per cycle back-to-back.
REQ-030 Writes SHALL produce no rvalid.
REQ-031 When only one port requests, that port SHALL be granted in the same cycle.
REQ-032 rdata outputs SHALL pass memRdata through unregistered, and are don't-care when the matching rvalid is 0.

Reset
REQ-033 While reset is high:
 - The FSM SHALL go to IDLE and the round-robin pointer SHALL point to the data port.
 - ifGnt, dGnt, memEn, memWe, ifRvalid and dRvalid SHALL be 0.
REQ-034 A response pending when reset is asserted SHALL be discarded; no rvalid is issued in the cycle after reset.

Configuration
REQ-035 Macro MEM_ARB_ROUND_ROBIN_EN selects the arbitration policy.
 - When defined: on simultaneous requests, the port not granted last wins. The pointer updates only on a contested grant.
 - When undefined: fixed priority, data port always wins, and the pointer logic is absent.

Verification
REQ-036 Reset, then ifReq=1, ifAddr=0x10, memRdata=0xDEADBEEF next cycle -> ifGnt=1 and memAddr=0x10 in cycle 0; ifRvalid=1 and ifRdata=0xDEADBEEF in cycle 1.
REQ-037 dReq=1, dWe=1, dMask=0x3, dAddr=0x104, dWdata=0x1234 -> dGnt=1, memWe=1, memMask=0x3 same cycle; dRvalid=0 the next cycle.
REQ-038 ifReq=dReq=1 for 4 cycles:
 - Without the macro: dGnt=1 every cycle, ifGnt=0.
 - With the macro: grants alternate D, IF, D, IF.
REQ-039 Data reads at 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive dRvalid pulses, each one cycle after its grant, with data in order.
REQ-040 Fetch granted, reset asserted in the following cycle -> ifRvalid=0 during reset and in the cycle after reset.
